// File: rtl/spi_mailbox_master.sv
// SPI mode-0 master for the 8-byte Z80 mailbox link.
// One SS-low frame per start: shifts NUM_BYTES bytes out of tx_buf and
// captures the same number of bytes into rx_buf, MSB first.
`timescale 1ns/1ps
module spi_mailbox_master #(
   parameter int unsigned CLK_DIV   = 4,   // clk cycles per SCK half-period, >= 1
   parameter int unsigned NUM_BYTES = 8,   // bytes per frame, 1..8
   parameter int unsigned CS_SETUP  = 4,   // SS-low cycles before the first bit, >= 1
   parameter int unsigned BYTE_GAP  = 16,  // idle cycles between bytes, >= 1
   parameter int unsigned CS_HOLD   = 4    // cycles from last SCK fall to SS rise, >= 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   output logic       busy,
   output logic       done,
   input  logic       tx_wr_en,
   input  logic [2:0] tx_wr_addr,
   input  logic [7:0] tx_wr_data,
   input  logic [2:0] rx_rd_addr,
   output logic [7:0] rx_rd_data,
   output logic       spi_sck,
   output logic       spi_ss,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_GAP,
      ST_HOLD
   } state_t;

   // One shared phase counter serves every timed state.
   localparam int unsigned MAX_A = (CLK_DIV  > CS_SETUP) ? CLK_DIV  : CS_SETUP;
   localparam int unsigned MAX_B = (BYTE_GAP > CS_HOLD)  ? BYTE_GAP : CS_HOLD;
   localparam int unsigned MAX_C = (MAX_A    > MAX_B)    ? MAX_A    : MAX_B;
   localparam int unsigned CNT_W = (MAX_C < 2) ? 1 : $clog2(MAX_C);

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV  - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BYTE_GAP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD  - 1);
   localparam logic [2:0]       BYTE_LAST  = 3'(NUM_BYTES - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       byte_q;
   logic [2:0]       bit_q;
   logic [7:0]       rx_sh_q;
   logic             sck_q;
   logic             ss_q;
   logic             mosi_q;
   logic             busy_q;
   logic             done_q;
   logic [7:0]       tx_buf_q [8];
   logic [7:0]       rx_buf_q [8];
   logic             next_bit_d;
   logic             next_msb_d;

   assign spi_sck    = sck_q;
   assign spi_ss     = ss_q;
   assign spi_mosi   = mosi_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign rx_rd_data = rx_buf_q[rx_rd_addr];

   // Next MOSI values: the following bit of this byte, or the next byte's MSB.
   always_comb begin
      next_bit_d = tx_buf_q[byte_q][3'(bit_q - 3'd1)];
      next_msb_d = tx_buf_q[3'(byte_q + 3'd1)][7];
   end

   // TX buffer: host writes land only while the FSM is idle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < 8; i++) tx_buf_q[i] <= '0;
      end else if (tx_wr_en && (state_q == ST_IDLE)) begin
         tx_buf_q[tx_wr_addr] <= tx_wr_data;
      end
   end

   // Frame sequencer: SS framing, SCK generation, MOSI shifting, MISO capture.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         byte_q  <= '0;
         bit_q   <= '0;
         rx_sh_q <= '0;
         sck_q   <= 1'b0;
         ss_q    <= 1'b1;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int unsigned i = 0; i < 8; i++) rx_buf_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  ss_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  mosi_q  <= tx_buf_q[0][7];
                  byte_q  <= '0;
                  bit_q   <= 3'd7;
                  cnt_q   <= '0;
                  state_q <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_SHIFT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_SHIFT: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q <= '0;
                  if (!sck_q) begin
                     // Rising edge: capture MISO.
                     sck_q   <= 1'b1;
                     rx_sh_q <= {rx_sh_q[6:0], spi_miso};
                  end else begin
                     // Falling edge: advance MOSI or close out the byte.
                     sck_q <= 1'b0;
                     if (bit_q != 3'd0) begin
                        bit_q  <= bit_q - 3'd1;
                        mosi_q <= next_bit_d;
                     end else begin
                        rx_buf_q[byte_q] <= rx_sh_q;
                        bit_q            <= 3'd7;
                        if (byte_q == BYTE_LAST) begin
                           state_q <= ST_HOLD;
                        end else begin
                           byte_q  <= byte_q + 3'd1;
                           mosi_q  <= next_msb_d;
                           state_q <= ST_GAP;
                        end
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_SHIFT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_q   <= '0;
                  ss_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  mosi_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mailbox_master.sv
// Self-checking bench for spi_mailbox_master: a default-parameter instance
// in MISO/MOSI loopback and a CLK_DIV=1, NUM_BYTES=3 instance against a
// scripted slave that returns a fixed response stream.
`timescale 1ns/1ps
module tb_spi_mailbox_master;

   localparam int unsigned A_DIV  = 4;
   localparam int unsigned A_NB   = 8;
   localparam int unsigned B_DIV  = 1;
   localparam int unsigned B_NB   = 3;
   localparam int unsigned SETUP  = 4;
   localparam int unsigned GAP    = 16;
   localparam int unsigned HOLD   = 4;
   localparam int unsigned A_BUSY = SETUP + A_NB * 16 * A_DIV + (A_NB - 1) * GAP + HOLD;
   localparam int unsigned B_BUSY = SETUP + B_NB * 16 * B_DIV + (B_NB - 1) * GAP + HOLD;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic       a_start, a_busy, a_done, a_wr_en, a_sck, a_ss, a_mosi, a_miso;
   logic [2:0] a_wr_addr, a_rd_addr;
   logic [7:0] a_wr_data, a_rd_data;
   logic       b_start, b_busy, b_done, b_wr_en, b_sck, b_ss, b_mosi, b_miso;
   logic [2:0] b_wr_addr, b_rd_addr;
   logic [7:0] b_wr_data, b_rd_data;

   assign a_miso = a_mosi;

   spi_mailbox_master #(.CLK_DIV(A_DIV), .NUM_BYTES(A_NB), .CS_SETUP(SETUP),
                        .BYTE_GAP(GAP), .CS_HOLD(HOLD)) u_a (
      .clk(clk), .resetn(resetn), .start(a_start), .busy(a_busy), .done(a_done),
      .tx_wr_en(a_wr_en), .tx_wr_addr(a_wr_addr), .tx_wr_data(a_wr_data),
      .rx_rd_addr(a_rd_addr), .rx_rd_data(a_rd_data),
      .spi_sck(a_sck), .spi_ss(a_ss), .spi_mosi(a_mosi), .spi_miso(a_miso));

   spi_mailbox_master #(.CLK_DIV(B_DIV), .NUM_BYTES(B_NB), .CS_SETUP(SETUP),
                        .BYTE_GAP(GAP), .CS_HOLD(HOLD)) u_b (
      .clk(clk), .resetn(resetn), .start(b_start), .busy(b_busy), .done(b_done),
      .tx_wr_en(b_wr_en), .tx_wr_addr(b_wr_addr), .tx_wr_data(b_wr_data),
      .rx_rd_addr(b_rd_addr), .rx_rd_data(b_rd_data),
      .spi_sck(b_sck), .spi_ss(b_ss), .spi_mosi(b_mosi), .spi_miso(b_miso));

   // Observers for instance A: SCK rises, MOSI stream, busy length, done pulses, SS-high gap.
   int unsigned a_rises = 0, a_done_cnt = 0, a_busy_len = 0, a_ss_run = 0, a_ss_gap = 0;
   logic        a_sck_p = 1'b0, a_ss_p = 1'b1, a_busy_p = 1'b0;
   logic [63:0] a_stream = '0;
   always @(negedge clk) begin
      a_sck_p  <= a_sck;
      a_ss_p   <= a_ss;
      a_busy_p <= a_busy;
      if (a_done === 1'b1) a_done_cnt <= a_done_cnt + 1;
      if (a_busy === 1'b1) a_busy_len <= (a_busy_p === 1'b1) ? a_busy_len + 1 : 1;
      if (a_ss === 1'b0 && a_ss_p === 1'b1) begin
         a_stream <= '0;
         a_ss_gap <= a_ss_run;
         a_ss_run <= 0;
      end else if (a_ss === 1'b1) begin
         a_ss_run <= a_ss_run + 1;
      end
      if (a_ss === 1'b0 && a_sck === 1'b1 && a_sck_p === 1'b0) begin
         a_rises  <= a_rises + 1;
         a_stream <= {a_stream[62:0], a_mosi};
      end
   end

   // Scripted slave and observers for instance B: MISO bit chosen by frame rise index.
   int unsigned b_fr = 0, b_low = 0, b_gap1 = 0, b_gap2 = 0, b_busy_len = 0;
   logic        b_sck_p = 1'b0, b_ss_p = 1'b1, b_busy_p = 1'b0;
   logic [23:0] b_stream = '0;
   logic [23:0] b_resp = '0;
   assign b_miso = (b_fr < 24) ? b_resp[23 - b_fr] : 1'b0;
   always @(negedge clk) begin
      b_sck_p  <= b_sck;
      b_ss_p   <= b_ss;
      b_busy_p <= b_busy;
      if (b_busy === 1'b1) b_busy_len <= (b_busy_p === 1'b1) ? b_busy_len + 1 : 1;
      if (b_ss === 1'b0 && b_ss_p === 1'b1) begin
         b_fr     <= 0;
         b_stream <= '0;
      end
      if (b_ss !== 1'b0) b_low <= 0;
      else if (b_sck === 1'b0) b_low <= b_low + 1;
      if (b_ss === 1'b0 && b_sck === 1'b1 && b_sck_p === 1'b0) begin
         b_fr     <= b_fr + 1;
         b_low    <= 0;
         b_stream <= {b_stream[22:0], b_mosi};
         if (b_fr == 8)  b_gap1 <= b_low;
         if (b_fr == 16) b_gap2 <= b_low;
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic a_write(input int unsigned i, input logic [7:0] v);
      a_wr_en = 1'b1; a_wr_addr = 3'(i); a_wr_data = v;
      tick(1);
      a_wr_en = 1'b0;
   endtask

   task automatic b_write(input int unsigned i, input logic [7:0] v);
      b_wr_en = 1'b1; b_wr_addr = 3'(i); b_wr_data = v;
      tick(1);
      b_wr_en = 1'b0;
   endtask

   task automatic a_read(input int unsigned i, output logic [7:0] v);
      a_rd_addr = 3'(i);
      #1;
      v = a_rd_data;
   endtask

   task automatic b_read(input int unsigned i, output logic [7:0] v);
      b_rd_addr = 3'(i);
      #1;
      v = b_rd_data;
   endtask

   task automatic pulse_a();
      a_start = 1'b1; tick(1); a_start = 1'b0;
   endtask

   task automatic wait_done_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick(1);
         if (a_done === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_done_b(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick(1);
         if (b_done === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      resetn = 1'b0;
      tick(3);
      checks++;
      if ({a_ss, a_sck, a_mosi, a_busy, a_done} !== 5'b10000) begin
         errors++; $display("FAIL reset_outputs_a ss/sck/mosi/busy/done got %b want 10000", {a_ss, a_sck, a_mosi, a_busy, a_done});
      end
      checks++;
      if ({b_ss, b_sck, b_mosi, b_busy, b_done} !== 5'b10000) begin
         errors++; $display("FAIL reset_outputs_b ss/sck/mosi/busy/done got %b want 10000", {b_ss, b_sck, b_mosi, b_busy, b_done});
      end
      for (int i = 0; i < 8; i++) begin
         a_read(i, d);
         checks++;
         if (d !== 8'h00) begin errors++; $display("FAIL reset_rx[%0d] got %h want 00", i, d); end
      end
      resetn = 1'b1;
      tick(1);
   endtask

   // Loopback frame on A: rx must equal tx, MOSI stream must be tx MSB-first.
   task automatic test_loopback(input bit rnd);
      logic [7:0]  tx [8];
      logic [7:0]  d;
      logic [63:0] exp_stream;
      int unsigned d0, r0;
      bit          ok;
      exp_stream = '0;
      for (int i = 0; i < 8; i++) begin
         tx[i] = rnd ? 8'($urandom) : 8'(32'h11 * (i + 1));
         a_write(i, tx[i]);
         exp_stream = {exp_stream[55:0], tx[i]};
      end
      d0 = a_done_cnt; r0 = a_rises;
      pulse_a();
      checks++;
      if (a_busy !== 1'b1 || a_ss !== 1'b0) begin
         errors++; $display("FAIL loop_start busy/ss got %b%b want 10", a_busy, a_ss);
      end
      wait_done_a(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL loop_done_timeout got no done want done"); end
      checks++;
      if (a_busy_len !== A_BUSY) begin errors++; $display("FAIL loop_busy_len got %0d want %0d", a_busy_len, A_BUSY); end
      tick(2);
      checks++;
      if (a_done_cnt - d0 !== 1) begin errors++; $display("FAIL loop_done_pulses got %0d want 1", a_done_cnt - d0); end
      checks++;
      if (a_rises - r0 !== 64) begin errors++; $display("FAIL loop_sck_rises got %0d want 64", a_rises - r0); end
      checks++;
      if (a_stream !== exp_stream) begin errors++; $display("FAIL loop_mosi_stream got %h want %h", a_stream, exp_stream); end
      for (int i = 0; i < 8; i++) begin
         a_read(i, d);
         checks++;
         if (d !== tx[i]) begin errors++; $display("FAIL loop_rx[%0d] got %h want %h", i, d, tx[i]); end
      end
   endtask

   // Instance B against the scripted slave.
   task automatic test_slave_b(input logic [23:0] resp);
      logic [7:0]  tx [8];
      logic [7:0]  d;
      logic [7:0]  want;
      logic [23:0] exp_stream;
      bit          ok;
      exp_stream = '0;
      for (int i = 0; i < 8; i++) begin
         tx[i] = 8'($urandom);
         b_write(i, tx[i]);
         if (i < 3) exp_stream = {exp_stream[15:0], tx[i]};
      end
      b_resp = resp;
      b_start = 1'b1; tick(1); b_start = 1'b0;
      wait_done_b(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL slave_done_timeout got no done want done"); end
      checks++;
      if (b_busy_len !== B_BUSY) begin errors++; $display("FAIL slave_busy_len got %0d want %0d", b_busy_len, B_BUSY); end
      // SCK-low run at a byte boundary is the gap plus the first bit's low phase.
      checks++;
      if (b_gap1 !== GAP + B_DIV || b_gap2 !== GAP + B_DIV) begin
         errors++; $display("FAIL slave_gap_low got %0d/%0d want %0d", b_gap1, b_gap2, GAP + B_DIV);
      end
      checks++;
      if (b_stream !== exp_stream) begin errors++; $display("FAIL slave_mosi_stream got %h want %h", b_stream, exp_stream); end
      for (int i = 0; i < 8; i++) begin
         b_read(i, d);
         want = (i < 3) ? resp[8 * (2 - i) +: 8] : 8'h00;
         checks++;
         if (d !== want) begin errors++; $display("FAIL slave_rx[%0d] got %h want %h", i, d, want); end
      end
   endtask

   task automatic test_ignored();
      logic [7:0]  tx [8];
      logic [7:0]  d;
      int unsigned d0, r0;
      bit          ok;
      for (int i = 0; i < 8; i++) begin
         tx[i] = 8'($urandom);
         if (i == 0 && tx[i] == 8'hEE) tx[i] = 8'h5C;
         a_write(i, tx[i]);
      end
      d0 = a_done_cnt; r0 = a_rises;
      pulse_a();
      tick(30);
      a_start = 1'b1; a_wr_en = 1'b1; a_wr_addr = 3'd0; a_wr_data = 8'hEE;
      tick(1);
      a_start = 1'b0; a_wr_en = 1'b0;
      wait_done_a(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ign_done_timeout got no done want done"); end
      checks++;
      if (a_busy_len !== A_BUSY) begin errors++; $display("FAIL ign_busy_len got %0d want %0d", a_busy_len, A_BUSY); end
      tick(5);
      checks++;
      if (a_busy !== 1'b0 || a_ss !== 1'b1) begin errors++; $display("FAIL ign_not_queued busy/ss got %b%b want 01", a_busy, a_ss); end
      checks++;
      if (a_done_cnt - d0 !== 1) begin errors++; $display("FAIL ign_done_pulses got %0d want 1", a_done_cnt - d0); end
      checks++;
      if (a_rises - r0 !== 64) begin errors++; $display("FAIL ign_sck_rises got %0d want 64", a_rises - r0); end
      for (int i = 0; i < 8; i++) begin
         a_read(i, d);
         checks++;
         if (d !== tx[i]) begin errors++; $display("FAIL ign_rx[%0d] got %h want %h", i, d, tx[i]); end
      end
      pulse_a();
      wait_done_a(ok);
      a_read(0, d);
      checks++;
      if (d !== tx[0]) begin errors++; $display("FAIL ign_txbuf0_kept got %h want %h", d, tx[0]); end
   endtask

   task automatic test_reset_mid();
      logic [7:0]  d;
      int unsigned d0;
      for (int i = 0; i < 8; i++) a_write(i, 8'($urandom));
      pulse_a();
      d0 = a_done_cnt;
      tick(98);
      resetn = 1'b0;
      tick(1);
      checks++;
      if ({a_ss, a_sck, a_busy, a_done} !== 4'b1000) begin
         errors++; $display("FAIL rmid_outputs ss/sck/busy/done got %b want 1000", {a_ss, a_sck, a_busy, a_done});
      end
      resetn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_read(i, d);
         checks++;
         if (d !== 8'h00) begin errors++; $display("FAIL rmid_rx[%0d] got %h want 00", i, d); end
      end
      tick(700);
      checks++;
      if (a_done_cnt !== d0 || a_ss !== 1'b1) begin
         errors++; $display("FAIL rmid_no_done done_pulses/ss got %0d/%b want 0/1", a_done_cnt - d0, a_ss);
      end
      test_loopback(1'b1);
   endtask

   task automatic test_back_to_back();
      logic [7:0] tx [8];
      logic [7:0] d;
      bit         ok;
      for (int i = 0; i < 8; i++) begin
         tx[i] = 8'($urandom);
         a_write(i, tx[i]);
      end
      pulse_a();
      tick(A_BUSY - 1);
      a_start = 1'b1;            // sampled on the edge that ends HOLD: ignored
      tick(1);
      checks++;
      if ({a_done, a_ss, a_busy} !== 3'b110) begin
         errors++; $display("FAIL b2b_end_of_frame done/ss/busy got %b want 110", {a_done, a_ss, a_busy});
      end
      tick(1);                   // sampled in the done cycle: accepted
      a_start = 1'b0;
      checks++;
      if (a_ss !== 1'b0 || a_busy !== 1'b1) begin
         errors++; $display("FAIL b2b_restart ss/busy got %b%b want 01", a_ss, a_busy);
      end
      tick(1);
      checks++;
      if (a_ss_gap !== 1) begin errors++; $display("FAIL b2b_ss_high got %0d want 1", a_ss_gap); end
      wait_done_a(ok);
      checks++;
      if (!ok || a_busy_len !== A_BUSY) begin
         errors++; $display("FAIL b2b_second_len got %0d (done %0d) want %0d", a_busy_len, ok, A_BUSY);
      end
      for (int i = 0; i < 8; i++) begin
         a_read(i, d);
         checks++;
         if (d !== tx[i]) begin errors++; $display("FAIL b2b_rx[%0d] got %h want %h", i, d, tx[i]); end
      end
   endtask

   initial begin
      resetn  = 1'b0;
      a_start = 1'b0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
      b_start = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
      test_reset();
      test_loopback(1'b0);
      test_loopback(1'b1);
      test_slave_b(24'hA55AFF);
      test_slave_b(24'($urandom));
      test_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
